// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl: framed command sequencer between the UART FIFOs and the ALU.
// Define UART_FRAME_CHECKSUM_EN to add a trailing XOR checksum byte to every frame.
module uart_alu_frame_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    OPCODE_SZ      = 6,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] ACK_BYTE       = 8'h06,
    parameter logic [DATA_WIDTH-1:0] NAK_BYTE       = 8'h15,
    parameter int                    ALU_LAT        = 1,
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_rx_empty,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    output logic                  o_rd_uart,
    input  logic                  i_tx_full,
    output logic                  o_wr_uart,
    output logic [DATA_WIDTH-1:0] o_w_data,
    input  logic [DATA_WIDTH-1:0] i_result_data,
    output logic [DATA_WIDTH-1:0] o_op_a,
    output logic [DATA_WIDTH-1:0] o_op_b,
    output logic [OPCODE_SZ-1:0]  o_op_code,
    output logic                  o_busy,
    output logic                  o_frame_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int OP_SHW = DATA_WIDTH;
`else
    localparam int OP_SHW = OPCODE_SZ;
`endif

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_GET_OP,
        ST_GET_A,
        ST_GET_B,
`ifdef UART_FRAME_CHECKSUM_EN
        ST_GET_CK,
`endif
        ST_EXEC,
        ST_TX_STAT,
        ST_TX_RES,
        ST_TX_NAK
    } state_t;

    state_t                state_reg;
    logic [OP_SHW-1:0]     op_shadow_reg;
    logic [DATA_WIDTH-1:0] a_reg;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] b_reg;
    logic                  ck_ok;
`endif
    logic [DATA_WIDTH-1:0] result_reg;
    logic [TMR_W-1:0]      tmr_reg;
    logic [LAT_W-1:0]      lat_reg;
    logic [OPCODE_SZ-1:0]  op_code_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;

    logic                  receiving;
    logic                  rx_take;
    logic                  tx_take;
    logic                  tmr_expired;
    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_b;
    logic [DATA_WIDTH-1:0] w_data;

    always_comb begin
        receiving = 1'b0;
        case (state_reg)
            ST_HUNT, ST_GET_OP, ST_GET_A, ST_GET_B: receiving = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            ST_GET_CK: receiving = 1'b1;
`endif
            default: receiving = 1'b0;
        endcase
    end

    // Pop is combinational so the FIFO advances at the same edge the byte is captured.
    assign rx_take     = i_reset_n & receiving & ~i_rx_empty;
    assign tx_take     = ~i_tx_full & ((state_reg == ST_TX_STAT) ||
                                       (state_reg == ST_TX_RES)  ||
                                       (state_reg == ST_TX_NAK));
    assign tmr_expired = i_rx_empty && (tmr_reg == TMR_LAST);

`ifdef UART_FRAME_CHECKSUM_EN
    assign ck_ok    = (i_r_data == (op_shadow_reg ^ a_reg ^ b_reg));
    assign commit   = rx_take && (state_reg == ST_GET_CK) && ck_ok;
    assign commit_b = b_reg;
`else
    // Operand B goes straight from the FIFO head into the committed register.
    assign commit   = rx_take && (state_reg == ST_GET_B);
    assign commit_b = i_r_data;
`endif

    always_comb begin
        w_data = '0;
        case (state_reg)
            ST_TX_STAT: w_data = ACK_BYTE;
            ST_TX_RES:  w_data = result_reg;
            ST_TX_NAK:  w_data = NAK_BYTE;
            default:    w_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_HUNT;
            op_shadow_reg <= '0;
            a_reg         <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            b_reg         <= '0;
`endif
            result_reg    <= '0;
            tmr_reg       <= '0;
            lat_reg       <= '0;
            op_code_reg   <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
        end else begin
            // Every GET_* entry coincides with a consumed byte, which clears the timer.
            if (rx_take) begin
                tmr_reg <= '0;
            end else if (receiving && (state_reg != ST_HUNT) && !tmr_expired) begin
                tmr_reg <= tmr_reg + TMR_W'(1);
            end

            if (commit) begin
                op_code_reg <= op_shadow_reg[OPCODE_SZ-1:0];
                op_a_reg    <= a_reg;
                op_b_reg    <= commit_b;
                lat_reg     <= '0;
            end

            case (state_reg)
                ST_HUNT: begin
                    if (rx_take && (i_r_data == SYNC_BYTE)) state_reg <= ST_GET_OP;
                end
                ST_GET_OP: begin
                    if (rx_take) begin
                        op_shadow_reg <= i_r_data[OP_SHW-1:0];
                        state_reg     <= ST_GET_A;
                    end else if (tmr_expired) begin
                        state_reg <= ST_TX_NAK;
                    end
                end
                ST_GET_A: begin
                    if (rx_take) begin
                        a_reg     <= i_r_data;
                        state_reg <= ST_GET_B;
                    end else if (tmr_expired) begin
                        state_reg <= ST_TX_NAK;
                    end
                end
                ST_GET_B: begin
                    if (rx_take) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        b_reg     <= i_r_data;
                        state_reg <= ST_GET_CK;
`else
                        state_reg <= ST_EXEC;
`endif
                    end else if (tmr_expired) begin
                        state_reg <= ST_TX_NAK;
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_GET_CK: begin
                    if (rx_take) begin
                        state_reg <= ck_ok ? ST_EXEC : ST_TX_NAK;
                    end else if (tmr_expired) begin
                        state_reg <= ST_TX_NAK;
                    end
                end
`endif
                ST_EXEC: begin
                    if (lat_reg == LAT_LAST) begin
                        result_reg <= i_result_data;
                        state_reg  <= ST_TX_STAT;
                    end else begin
                        lat_reg <= lat_reg + LAT_W'(1);
                    end
                end
                ST_TX_STAT: begin
                    if (tx_take) state_reg <= ST_TX_RES;
                end
                ST_TX_RES, ST_TX_NAK: begin
                    if (tx_take) state_reg <= ST_HUNT;
                end
                default: state_reg <= ST_HUNT;
            endcase
        end
    end

    assign o_rd_uart   = rx_take;
    assign o_wr_uart   = tx_take;
    assign o_w_data    = w_data;
    assign o_frame_err = tx_take && (state_reg == ST_TX_NAK);
    assign o_busy      = (state_reg != ST_HUNT);
    assign o_op_code   = op_code_reg;
    assign o_op_a      = op_a_reg;
    assign o_op_b      = op_b_reg;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Bench for uart_alu_frame_ctrl: FIFO model, frame-level scoreboard and directed frames.
// Honours UART_FRAME_CHECKSUM_EN the same way as the design.
module tb_uart_alu_frame_ctrl;

    localparam int         LAT  = 2;
    localparam int         TO   = 20;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_rx_empty = 1'b1;
    logic       i_tx_full = 1'b0;
    logic [7:0] i_r_data = 8'h00;
    logic [7:0] i_result_data;
    logic       o_rd_uart, o_wr_uart, o_busy, o_frame_err;
    logic [7:0] o_w_data, o_op_a, o_op_b;
    logic [5:0] o_op_code;

    always #5 i_clk = ~i_clk;

    // Reference ALU: also drives i_result_data from the committed operands.
    function automatic logic [7:0] alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h20:   return a + b;
            6'h25:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign i_result_data = alu(o_op_code, o_op_a, o_op_b);

    uart_alu_frame_ctrl #(
        .ALU_LAT(LAT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_rx_empty(i_rx_empty),
        .i_r_data(i_r_data),
        .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full),
        .o_wr_uart(o_wr_uart),
        .o_w_data(o_w_data),
        .i_result_data(i_result_data),
        .o_op_a(o_op_a),
        .o_op_b(o_op_b),
        .o_op_code(o_op_code),
        .o_busy(o_busy),
        .o_frame_err(o_frame_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    logic       rst_n_req = 1'b0;
    logic       tx_full_req = 1'b0;

    // expected TX stream, each entry with the operands that must be committed at push time
    logic [7:0] exp_byte[64];
    logic       exp_nak[64];
    logic [5:0] exp_op[64];
    logic [7:0] exp_a[64];
    logic [7:0] exp_b[64];
    int         exp_wr = 0;
    int         exp_rd = 0;
    logic [5:0] m_op = 6'h0;
    logic [7:0] m_a = 8'h0;
    logic [7:0] m_b = 8'h0;

    logic [7:0] tx_log[64];
    int         tx_cyc[64];
    int         tx_n = 0;
    int         pop_cyc[256];
    int         pop_n = 0;

    logic       s_busy, s_rd, s_wr, s_ferr;
    logic [7:0] s_wdata, s_a, s_b;
    logic [5:0] s_op;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: apply inputs on the falling edge, sample/compare, pop on the rising edge.
    task automatic step();
        logic pop_now;
        @(negedge i_clk);
        i_reset_n  = rst_n_req;
        i_tx_full  = tx_full_req;
        i_rx_empty = (rx_q.size() == 0);
        if (rx_q.size() != 0) i_r_data = rx_q[0];
        else                  i_r_data = 8'h00;
        #1;
        s_busy = o_busy;   s_rd = o_rd_uart; s_wr = o_wr_uart; s_ferr = o_frame_err;
        s_wdata = o_w_data; s_op = o_op_code; s_a = o_op_a;   s_b = o_op_b;
        pop_now = o_rd_uart;
        if (o_rd_uart && i_rx_empty) check("rd_while_empty", 1, 0);
        if (o_rd_uart && pop_n < 256) begin
            pop_cyc[pop_n] = cyc;
            pop_n++;
        end
        if (o_wr_uart) begin
            if (i_tx_full) check("wr_while_full", 1, 0);
            if (tx_n < 64) begin
                tx_log[tx_n] = o_w_data;
                tx_cyc[tx_n] = cyc;
                tx_n++;
            end
            if (exp_rd >= exp_wr) begin
                tests++;
                fails++;
                $display("FAIL unexpected_push: actual %0h required no push (cycle %0d)", o_w_data, cyc);
            end else begin
                check("tx_byte", o_w_data, exp_byte[exp_rd]);
                check("frame_err", o_frame_err, exp_nak[exp_rd]);
                check("op_code", o_op_code, exp_op[exp_rd]);
                check("op_a", o_op_a, exp_a[exp_rd]);
                check("op_b", o_op_b, exp_b[exp_rd]);
                exp_rd++;
            end
        end else if (o_frame_err) begin
            check("frame_err_no_push", 1, 0);
        end
        cyc++;
        @(posedge i_clk);
        if (pop_now && rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic nak);
        exp_byte[exp_wr] = b;
        exp_nak[exp_wr]  = nak;
        exp_op[exp_wr]   = m_op;
        exp_a[exp_wr]    = m_a;
        exp_b[exp_wr]    = m_b;
        exp_wr++;
    endtask

    function automatic logic [7:0] ckof(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return op ^ a ^ b;
    endfunction

    // Frame-level model: decides ACK+result or NAK for a complete frame.
    task automatic model_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] ck);
        logic good;
`ifdef UART_FRAME_CHECKSUM_EN
        good = (ck == ckof(op, a, b));
`else
        good = 1'b1 | (ck == 8'h00);
`endif
        if (good) begin
            m_op = op[5:0];
            m_a  = a;
            m_b  = b;
            expect_byte(ACK, 1'b0);
            expect_byte(alu(m_op, a, b), 1'b0);
        end else begin
            expect_byte(NAK, 1'b1);
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] ck);
        rx_q.push_back(SYNC);
        rx_q.push_back(op);
        rx_q.push_back(a);
        rx_q.push_back(b);
`ifdef UART_FRAME_CHECKSUM_EN
        rx_q.push_back(ck);
`endif
        model_frame(op, a, b, ck);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_rd != exp_wr || s_busy) && n < budget) begin
            step();
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    int t0;
    int p0;
    int n;

    initial begin
        // reset state, with a byte waiting that must not be popped during reset
        rx_q.push_back(8'h37);
        rst_n_req = 1'b0;
        repeat (3) step();
        check("rst_busy", s_busy, 0);
        check("rst_rd", s_rd, 0);
        check("rst_wr", s_wr, 0);
        check("rst_ferr", s_ferr, 0);
        check("rst_wdata", s_wdata, 8'h00);
        check("rst_op", s_op, 6'h00);
        check("rst_a", s_a, 8'h00);
        check("rst_b", s_b, 8'h00);
        rst_n_req = 1'b1;
        wait_idle("discard_idle", 20);

        // reset in the middle of a frame, then a normal frame
        rx_q.push_back(SYNC);
        rx_q.push_back(8'h20);
        repeat (3) step();
        check("midframe_busy", s_busy, 1);
        rst_n_req = 1'b0;
        step();
        check("midframe_rst_busy", s_busy, 0);
        check("midframe_rst_op", s_op, 6'h00);
        rst_n_req = 1'b1;
        m_op = 6'h0; m_a = 8'h0; m_b = 8'h0;
        t0 = tx_n;
        send_frame(8'h25, 8'h09, 8'h04, ckof(8'h25, 8'h09, 8'h04));
        wait_idle("after_rst_idle", 60);
        check("after_rst_ack", tx_log[t0], 8'h06);
        check("after_rst_res", tx_log[t0+1], 8'h05);

        // garbage byte before SYNC, then the basic frame
        t0 = tx_n;
        rx_q.push_back(8'h37);
        send_frame(8'h20, 8'h05, 8'h03, 8'h26);
        wait_idle("basic_idle", 60);
        check("basic_push_cnt", tx_n - t0, 2);
        check("basic_ack", tx_log[t0], 8'h06);
        check("basic_res", tx_log[t0+1], 8'h08);
        check("basic_opc", s_op, 6'h20);
        check("basic_a", s_a, 8'h05);
        check("basic_b", s_b, 8'h03);
        check("basic_latency", tx_cyc[t0] - pop_cyc[pop_n-1], LAT + 1);
        check("basic_res_next", tx_cyc[t0+1] - tx_cyc[t0], 1);

        // inter-byte timeout after SYNC,OP,A
        t0 = tx_n;
        rx_q.push_back(SYNC);
        rx_q.push_back(8'h40);
        rx_q.push_back(8'h11);
        expect_byte(NAK, 1'b1);
        wait_idle("timeout_idle", 100);
        check("timeout_push_cnt", tx_n - t0, 1);
        check("timeout_nak", tx_log[t0], 8'h15);
        check("timeout_delay", tx_cyc[t0] - pop_cyc[pop_n-1], TO + 1);
        check("timeout_op_kept", s_op, 6'h20);
        check("timeout_busy", s_busy, 0);

        // byte arriving in the expiry cycle is consumed and no NAK follows
        t0 = tx_n;
        rx_q.push_back(SYNC);
        rx_q.push_back(8'h25);
        rx_q.push_back(8'h0C);
        n = 0;
        while (rx_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("expiry_pre_pops", (n < 20), 1);
        repeat (TO - 1) step();
        rx_q.push_back(8'h03);
`ifdef UART_FRAME_CHECKSUM_EN
        rx_q.push_back(ckof(8'h25, 8'h0C, 8'h03));
`endif
        model_frame(8'h25, 8'h0C, 8'h03, ckof(8'h25, 8'h0C, 8'h03));
        wait_idle("expiry_idle", 60);
        check("expiry_ack", tx_log[t0], 8'h06);
        check("expiry_res", tx_log[t0+1], 8'h09);

        // TX FIFO full while the status byte is pending
        t0 = tx_n;
        tx_full_req = 1'b1;
        send_frame(8'h30, 8'h07, 8'h02, ckof(8'h30, 8'h07, 8'h02));
        repeat (22) step();
        check("stall_no_push", tx_n - t0, 0);
        check("stall_busy", s_busy, 1);
        tx_full_req = 1'b0;
        wait_idle("stall_idle", 40);
        check("stall_push_cnt", tx_n - t0, 2);
        check("stall_ack", tx_log[t0], 8'h06);
        check("stall_res", tx_log[t0+1], 8'h05);

`ifdef UART_FRAME_CHECKSUM_EN
        // good and bad checksum
        t0 = tx_n;
        send_frame(8'h20, 8'h05, 8'h03, 8'h26);
        send_frame(8'h20, 8'h05, 8'h03, 8'h27);
        wait_idle("ck_idle", 120);
        check("ck_push_cnt", tx_n - t0, 3);
        check("ck_good_ack", tx_log[t0], 8'h06);
        check("ck_good_res", tx_log[t0+1], 8'h08);
        check("ck_bad_nak", tx_log[t0+2], 8'h15);
`endif

        // two frames queued back to back; second carries a SYNC value as data
        t0 = tx_n;
        p0 = pop_n;
        send_frame(8'h20, 8'h11, 8'h22, ckof(8'h20, 8'h11, 8'h22));
        send_frame(8'h25, 8'hA5, 8'h05, ckof(8'h25, 8'hA5, 8'h05));
        wait_idle("b2b_idle", 120);
        check("b2b_push_cnt", tx_n - t0, 4);
        check("b2b_ack1", tx_log[t0], 8'h06);
        check("b2b_res1", tx_log[t0+1], 8'h33);
        check("b2b_ack2", tx_log[t0+2], 8'h06);
        check("b2b_res2", tx_log[t0+3], 8'hA0);
        check("b2b_second_pop_after_res", (pop_cyc[p0+FL] > tx_cyc[t0+1]), 1);
        check("b2b_opc", s_op, 6'h25);
        check("b2b_a", s_a, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
